// File: rtl/hdmi_info_frame_pkg.sv
// Shared constants and types for the HDMI audio InfoFrame receiver.
package hdmi_info_frame_pkg;

    localparam logic [7:0] INFO_FRAME_TYPE_AUDIO = 8'h84;
    localparam logic [7:0] AUDIO_IF_VERSION      = 8'h01;
    localparam logic [7:0] AUDIO_IF_LENGTH       = 8'h0A;
    // g(x) = 1 + x^6 + x^7 + x^8 in bit-reversed form for an LSB-first LFSR
    localparam logic [7:0] BCH_POLY_MASK         = 8'h83;

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } rx_state_t;

    typedef struct packed {
        logic [2:0] channel_count;
        logic [7:0] allocation;
        logic       dm_inh;
        logic [3:0] lsv;
        logic [1:0] lfe_pbl;
        logic [3:0] coding_type;
        logic [2:0] freq;
        logic [1:0] size;
    } audio_fields_t;

    function automatic logic [7:0] byte_sum(input logic [23:0] hdr, input logic [87:0] pb);
        logic [7:0] s;
        s = hdr[7:0] + hdr[15:8] + hdr[23:16];
        for (int k = 0; k < 11; k++) begin
            s = s + pb[8*k +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/bch_ecc_checker.sv
// Serial BCH parity checker: DATA_LEN data bits then 8 parity bits, LSB first,
// BITS_PER_STEP bits per slot. o_err includes the current slot's comparison.
module bch_ecc_checker
    import hdmi_info_frame_pkg::*;
#(
    parameter int DATA_LEN      = 24,
    parameter int BITS_PER_STEP = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic [4:0]               i_pos,
    input  logic [BITS_PER_STEP-1:0] i_bits,
    output logic                     o_err
);

    logic [7:0] r_crc;
    logic       r_err;
    logic [7:0] w_crc;
    logic       w_err;
    logic       w_fb;
    logic [6:0] w_num;
    logic [2:0] w_pidx;

    always_comb begin
        w_crc  = i_clear ? 8'h00 : r_crc;
        w_err  = i_clear ? 1'b0 : r_err;
        w_fb   = 1'b0;
        w_num  = '0;
        w_pidx = '0;
        if (i_en) begin
            for (int k = 0; k < BITS_PER_STEP; k++) begin
                w_num = 7'(i_pos) * 7'(BITS_PER_STEP) + 7'(k);
                if (w_num < 7'(DATA_LEN)) begin
                    w_fb  = i_bits[k] ^ w_crc[0];
                    w_crc = {1'b0, w_crc[7:1]} ^ (w_fb ? BCH_POLY_MASK : 8'h00);
                end else begin
                    // remainder is frozen once data ends, so parity is compared bitwise
                    w_pidx = 3'(w_num - 7'(DATA_LEN));
                    if (i_bits[k] != w_crc[w_pidx]) begin
                        w_err = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= '0;
            r_err <= 1'b0;
        end else if (i_en) begin
            r_crc <= w_crc;
            r_err <= w_err;
        end
    end

    assign o_err = w_err;

endmodule

// File: rtl/audio_info_frame_receiver.sv
// HDMI audio InfoFrame receiver: collects a 32-slot data-island packet, checks it
// two cycles after the last slot, and holds the last accepted frame's fields.
// Optional BCH parity checking is built when BCH_CHECK_EN is defined.
//
// state     | meaning
// S_IDLE    | waiting for packet_start with packet_bit_valid
// S_COLLECT | capturing slots 1..31 of the current packet
module audio_info_frame_receiver
    import hdmi_info_frame_pkg::*;
#(
    parameter int CHECK_STREAM_FIELDS = 1
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       packet_start,
    input  logic       packet_bit_valid,
    input  logic       header_bit,
    input  logic [7:0] sub_bits,
    output logic [2:0] audio_channel_count,
    output logic [7:0] channel_allocation,
    output logic       down_mix_inhibited,
    output logic [3:0] level_shift_value,
    output logic [1:0] lfe_playback_level,
    output logic [3:0] coding_type,
    output logic [2:0] sampling_frequency,
    output logic [1:0] sample_size,
    output logic       info_valid,
    output logic       info_update,
    output logic       checksum_error,
    output logic       format_error,
    output logic       ecc_error
);

    rx_state_t     r_state, w_state_next;
    logic [4:0]    r_idx;
    logic [23:0]   r_hdr;
    logic [55:0]   r_sp0;
    logic [31:0]   r_sp1;
    logic [23:0]   r_hold_hdr;
    logic [55:0]   r_hold_sp0;
    logic [31:0]   r_hold_sp1;
    logic          r_hold_vld;
    logic          r_hold_ecc;
    audio_fields_t r_fields;
    logic          r_info_valid, r_upd, r_cks, r_fmt, r_ecc;

    logic          w_begin, w_capture, w_last;
    logic [4:0]    w_pos;
    logic [4:0]    w_ecc_err;

    // a start at slot 31 is taken as the last bit, not a restart
    assign w_begin   = packet_bit_valid && packet_start && ((r_state == S_IDLE) || (r_idx != 5'd31));
    assign w_capture = w_begin || ((r_state == S_COLLECT) && packet_bit_valid);
    assign w_last    = (r_state == S_COLLECT) && packet_bit_valid && !w_begin && (r_idx == 5'd31);
    assign w_pos     = w_begin ? 5'd0 : r_idx;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_begin) w_state_next = S_COLLECT;
            S_COLLECT: if (!packet_bit_valid || w_last) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // only data bits are stored; each slot position is rewritten on every packet
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_idx      <= '0;
            r_hdr      <= '0;
            r_sp0      <= '0;
            r_sp1      <= '0;
            r_hold_hdr <= '0;
            r_hold_sp0 <= '0;
            r_hold_sp1 <= '0;
            r_hold_vld <= 1'b0;
            r_hold_ecc <= 1'b0;
        end else begin
            r_hold_vld <= w_last;
            if (w_capture) begin
                r_idx <= w_pos + 5'd1;
                if (w_pos < 5'd24) r_hdr[w_pos] <= header_bit;
                if (w_pos < 5'd28) r_sp0[{w_pos, 1'b0} +: 2] <= sub_bits[1:0];
                if (w_pos < 5'd16) r_sp1[{w_pos[3:0], 1'b0} +: 2] <= sub_bits[3:2];
            end
            if (w_last) begin
                r_hold_hdr <= r_hdr;
                r_hold_sp0 <= r_sp0;
                r_hold_sp1 <= r_sp1;
                r_hold_ecc <= |w_ecc_err;
            end
        end
    end

`ifdef BCH_CHECK_EN
    bch_ecc_checker #(.DATA_LEN(24), .BITS_PER_STEP(1)) u_bch_hdr (
        .i_clk   (clk_pixel),
        .i_rst_n (reset_n),
        .i_clear (w_begin),
        .i_en    (w_capture),
        .i_pos   (w_pos),
        .i_bits  (header_bit),
        .o_err   (w_ecc_err[0])
    );
    for (genvar j = 0; j < 4; j++) begin : g_bch_sub
        bch_ecc_checker #(.DATA_LEN(56), .BITS_PER_STEP(2)) u_bch_sub (
            .i_clk   (clk_pixel),
            .i_rst_n (reset_n),
            .i_clear (w_begin),
            .i_en    (w_capture),
            .i_pos   (w_pos),
            .i_bits  (sub_bits[2*j+1 -: 2]),
            .o_err   (w_ecc_err[j+1])
        );
    end
`else
    logic w_unused_sub;
    assign w_ecc_err    = '0;
    assign w_unused_sub = ^sub_bits[7:4];
`endif

    logic [7:0]    w_pb1, w_pb2, w_pb4, w_pb5;
    logic          w_is_audio, w_fmt, w_cks;
    audio_fields_t w_fields;

    always_comb begin
        w_pb1      = r_hold_sp0[15:8];
        w_pb2      = r_hold_sp0[23:16];
        w_pb4      = r_hold_sp0[39:32];
        w_pb5      = r_hold_sp0[47:40];
        w_is_audio = (r_hold_hdr[7:0] == INFO_FRAME_TYPE_AUDIO);
        w_fmt      = (r_hold_hdr[15:8] != AUDIO_IF_VERSION) || (r_hold_hdr[23:16] != AUDIO_IF_LENGTH);
        if (CHECK_STREAM_FIELDS != 0) begin
            w_fmt = w_fmt || (w_pb1[7:4] != 4'd0) || (w_pb2[4:0] != 5'd0);
        end
        w_cks = (byte_sum(r_hold_hdr, {r_hold_sp1, r_hold_sp0}) != 8'h00);
        w_fields = '{channel_count: w_pb1[2:0], allocation: w_pb4, dm_inh: w_pb5[7],
                     lsv: w_pb5[6:3], lfe_pbl: w_pb5[1:0], coding_type: w_pb1[7:4],
                     freq: w_pb2[4:2], size: w_pb2[1:0]};
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_fields     <= '0;
            r_info_valid <= 1'b0;
            r_upd        <= 1'b0;
            r_cks        <= 1'b0;
            r_fmt        <= 1'b0;
            r_ecc        <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            r_cks <= 1'b0;
            r_fmt <= 1'b0;
            r_ecc <= 1'b0;
            if (r_hold_vld && w_is_audio) begin
                r_cks <= w_cks;
                r_fmt <= w_fmt;
                r_ecc <= r_hold_ecc;
                if (!w_cks && !w_fmt && !r_hold_ecc) begin
                    r_fields     <= w_fields;
                    r_upd        <= 1'b1;
                    r_info_valid <= 1'b1;
                end
            end
        end
    end

    assign audio_channel_count = r_fields.channel_count;
    assign channel_allocation  = r_fields.allocation;
    assign down_mix_inhibited  = r_fields.dm_inh;
    assign level_shift_value   = r_fields.lsv;
    assign lfe_playback_level  = r_fields.lfe_pbl;
    assign coding_type         = r_fields.coding_type;
    assign sampling_frequency  = r_fields.freq;
    assign sample_size         = r_fields.size;
    assign info_valid          = r_info_valid;
    assign info_update         = r_upd;
    assign checksum_error      = r_cks;
    assign format_error        = r_fmt;
    assign ecc_error           = r_ecc;

endmodule

// File: tb/tb_audio_info_frame_receiver.sv
// Scoreboard bench for audio_info_frame_receiver: directed packets push expected
// pulses into a queue; a negedge monitor pops and compares them.
module tb_audio_info_frame_receiver;

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic       packet_start;
    logic       packet_bit_valid;
    logic       header_bit;
    logic [7:0] sub_bits;
    logic [2:0] audio_channel_count;
    logic [7:0] channel_allocation;
    logic       down_mix_inhibited;
    logic [3:0] level_shift_value;
    logic [1:0] lfe_playback_level;
    logic [3:0] coding_type;
    logic [2:0] sampling_frequency;
    logic [1:0] sample_size;
    logic       info_valid, info_update, checksum_error, format_error, ecc_error;

    audio_info_frame_receiver #(.CHECK_STREAM_FIELDS(1)) dut (
        .clk_pixel           (clk_pixel),
        .reset_n             (reset_n),
        .packet_start        (packet_start),
        .packet_bit_valid    (packet_bit_valid),
        .header_bit          (header_bit),
        .sub_bits            (sub_bits),
        .audio_channel_count (audio_channel_count),
        .channel_allocation  (channel_allocation),
        .down_mix_inhibited  (down_mix_inhibited),
        .level_shift_value   (level_shift_value),
        .lfe_playback_level  (lfe_playback_level),
        .coding_type         (coding_type),
        .sampling_frequency  (sampling_frequency),
        .sample_size         (sample_size),
        .info_valid          (info_valid),
        .info_update         (info_update),
        .checksum_error      (checksum_error),
        .format_error        (format_error),
        .ecc_error           (ecc_error)
    );

    always #5 clk_pixel = ~clk_pixel;

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;
        logic [26:0] fields;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [26:0] m_fields = '0;
    logic [111:0] pb;

    function automatic logic [26:0] dut_fields();
        return {audio_channel_count, channel_allocation, down_mix_inhibited, level_shift_value,
                lfe_playback_level, coding_type, sampling_frequency, sample_size};
    endfunction

    function automatic logic [3:0] dut_pulses();
        return {info_update, checksum_error, format_error, ecc_error};
    endfunction

    function automatic logic [26:0] decode(input logic [111:0] p);
        return {p[10:8], p[39:32], p[47], p[46:43], p[41:40], p[15:12], p[20:18], p[17:16]};
    endfunction

    function automatic logic [7:0] bch(input logic [55:0] d, input int len);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 0; i < len; i++) begin
            fb = d[i] ^ r[0];
            r  = {1'b0, r[7:1]} ^ (fb ? 8'h83 : 8'h00);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_pixel); #1;
            packet_bit_valid = 1'b0;
            packet_start     = 1'b0;
            header_bit       = 1'b0;
            sub_bits         = 8'h00;
        end
    endtask

    task automatic send(input logic [23:0] hdr, input logic [111:0] p, input int nbits,
                        input logic [3:0] exp_p, input bit flip_sp2);
        logic [31:0] h;
        logic [63:0] sp [4];
        h     = {bch({32'h0, hdr}, 24), hdr};
        sp[0] = {bch(p[55:0], 56), p[55:0]};
        sp[1] = {bch(p[111:56], 56), p[111:56]};
        sp[2] = {bch(56'h0, 56), 56'h0};
        sp[3] = {bch(56'h0, 56), 56'h0};
        if (flip_sp2) sp[2][59] = ~sp[2][59];
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk_pixel); #1;
            packet_bit_valid = 1'b1;
            packet_start     = (i == 0);
            header_bit       = h[i];
            for (int j = 0; j < 4; j++) sub_bits[2*j +: 2] = sp[j][2*i +: 2];
            if (i == 31 && exp_p != 4'b0000) begin
                if (exp_p[3]) m_fields = decode(p);
                q.push_back('{cyc + 2, exp_p, m_fields});
            end
        end
    endtask

    logic [3:0] mon_p;
    exp_t       mon_e;
    initial begin
        forever begin
            @(negedge clk_pixel);
            if (reset_n) begin
                mon_p = dut_pulses();
                if (mon_p != 4'b0000) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)", mon_p, cyc);
                    end else begin
                        mon_e = q.pop_front();
                        chk("pulse_cycle", cyc, mon_e.cyc);
                        chk("pulses", {28'h0, mon_p}, {28'h0, mon_e.pulses});
                        chk("fields", {5'h0, dut_fields()}, {5'h0, mon_e.fields});
                    end
                end else if (q.size() != 0 && q[0].cyc < cyc) begin
                    mon_e = q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_pulse: got none expected %b at cycle %0d", mon_e.pulses, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        packet_start     = 1'b0;
        packet_bit_valid = 1'b0;
        header_bit       = 1'b0;
        sub_bits         = 8'h00;
        repeat (3) @(posedge clk_pixel);
        #1;
        chk("reset_fields", {5'h0, dut_fields()}, 32'h0);
        chk("reset_flags", {27'h0, info_valid, dut_pulses()}, 32'h0);
        @(posedge clk_pixel); #1;
        reset_n = 1'b1;
        idle(2);

        // valid frame, channel count 1
        pb = '0; pb[7:0] = 8'h70; pb[15:8] = 8'h01;
        send(24'h0A0184, pb, 32, 4'b1000, 1'b0);
        idle(4);
        chk("info_valid_v1", {31'h0, info_valid}, 32'h1);
        chk("channel_count_v1", {29'h0, audio_channel_count}, 32'h1);

        // bad checksum
        pb[7:0] = 8'h6F;
        send(24'h0A0184, pb, 32, 4'b0100, 1'b0);
        idle(4);
        chk("info_valid_held", {31'h0, info_valid}, 32'h1);

        // version 02, checksum corrected
        send(24'h0A0284, pb, 32, 4'b0010, 1'b0);
        idle(4);

        // type 82: silently ignored
        pb[7:0] = 8'h70;
        send(24'h0A0182, pb, 32, 4'b0000, 1'b0);
        idle(4);

        // sample size nonzero, checksum corrected
        pb = '0; pb[7:0] = 8'h6F; pb[15:8] = 8'h01; pb[23:16] = 8'h01;
        send(24'h0A0184, pb, 32, 4'b0010, 1'b0);
        idle(4);

        // version error and checksum error together
        pb = '0; pb[7:0] = 8'h70; pb[15:8] = 8'h01;
        send(24'h0A0284, pb, 32, 4'b0110, 1'b0);
        idle(4);

        // many fields, PB8 contributes to checksum
        pb = '0; pb[7:0] = 8'h76; pb[15:8] = 8'h03; pb[39:32] = 8'h2F; pb[47:40] = 8'hB9; pb[71:64] = 8'h10;
        send(24'h0A0184, pb, 32, 4'b1000, 1'b0);
        idle(4);
        chk("dm_inh_v7", {31'h0, down_mix_inhibited}, 32'h1);
        chk("lsv_v7", {28'h0, level_shift_value}, 32'h7);

        // valid dropped at slot 10: discarded
        pb = '0; pb[7:0] = 8'h70; pb[15:8] = 8'h01;
        send(24'h0A0184, pb, 10, 4'b0000, 1'b0);
        idle(5);

        // back-to-back frames
        send(24'h0A0184, pb, 32, 4'b1000, 1'b0);
        pb[7:0] = 8'h5D; pb[39:32] = 8'h13;
        send(24'h0A0184, pb, 32, 4'b1000, 1'b0);
        idle(4);
        chk("allocation_b2b", {24'h0, channel_allocation}, 32'h13);

        // restart at slot 12, then a full frame
        pb = '0; pb[7:0] = 8'h70; pb[15:8] = 8'h01;
        send(24'h0A0184, pb, 12, 4'b0000, 1'b0);
        send(24'h0A0184, pb, 32, 4'b1000, 1'b0);
        idle(4);

        // reset at slot 20
        send(24'h0A0184, pb, 20, 4'b0000, 1'b0);
        @(posedge clk_pixel); #1;
        reset_n          = 1'b0;
        packet_bit_valid = 1'b0;
        packet_start     = 1'b0;
        #1;
        chk("midreset_fields", {5'h0, dut_fields()}, 32'h0);
        chk("midreset_flags", {27'h0, info_valid, dut_pulses()}, 32'h0);
        m_fields = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;
        idle(6);
        chk("info_valid_after_reset", {31'h0, info_valid}, 32'h0);

        // valid frame again
        send(24'h0A0184, pb, 32, 4'b1000, 1'b0);
        idle(4);
        chk("info_valid_v12", {31'h0, info_valid}, 32'h1);

`ifdef BCH_CHECK_EN
        // flipped parity bit in subpacket 2
        pb[7:0] = 8'h5D; pb[39:32] = 8'h13;
        send(24'h0A0184, pb, 32, 4'b0001, 1'b1);
        idle(4);
        chk("allocation_after_ecc", {24'h0, channel_allocation}, 32'h00);
`endif

        for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk_pixel);
        while (q.size() != 0) begin
            mon_e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL drain: got none expected %b at cycle %0d", mon_e.pulses, mon_e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
